vga_fun_ctrl: RTL and testbench
===============================

VGA_FUN_CTRL -- requirements
Module: vga_fun_ctrl

Interface
REQ-001 Parameters (name, default, meaning), one per line:
  H_VIS 640 visible pixels; H_FP 16 front porch; H_SYNC 96 sync width; H_BP 48 back porch.
  V_VIS 480 visible lines; V_FP 10; V_SYNC 2; V_BP 33.
REQ-002 Ports (name, direction, width, meaning), one per line:
  clk  in  1  pixel clock, 25.175 MHz nominal.
  rst_n  in  1  reset, active-low, asynchronous.
  mode  in  2  pattern select.
  pause  in  1  1 = freeze frame counter.
  hsync  out  1  horizontal sync, active-low.
  vsync  out  1  vertical sync, active-low.
  hblank  out  1  1 = outside visible columns.
  vblank  out  1  1 = outside visible lines.
  r  out  8  red code to DAC.
  g  out  8  green code to DAC.
  b  out  8  blue code to DAC.
  frame  out  8  frame counter.
REQ-003 Single clock domain clk; reset is asynchronous, active-low (rst_n).

Function
REQ-004 h counter SHALL count 0..H_TOTAL-1 (H_TOTAL = H_VIS+H_FP+H_SYNC+H_BP = 800), then wrap to 0.
REQ-005 v counter SHALL increment when h wraps; range 0..V_TOTAL-1 (525), then wraps to 0.
REQ-006 All outputs SHALL be registered; each output at edge n reflects counter values (h,v) held before edge n (1-clock latency).
REQ-007 hblank = 1 iff h >= H_VIS; vblank = 1 iff v >= V_VIS.
REQ-008 hsync = 0 iff H_VIS+H_FP <= h < H_VIS+H_FP+H_SYNC (656..751); else 1.
REQ-009 vsync = 0 iff V_VIS+V_FP <= v < V_VIS+V_FP+V_SYNC (490..491); else 1.
REQ-010 r, g, b SHALL be 0 whenever hblank or vblank would be 1 for that pixel.
REQ-011 Active mode register SHALL load from mode only when h=H_TOTAL-1 and v=V_TOTAL-1 (frame boundary); mid-frame mode changes are ignored until then.
REQ-012 Visible patterns, active mode:
  0 gradient: r=h[7:0], g=v[7:0], b=frame.
  1 colour bars: bar = h/80 (0..7); r=255*bar[2], g=255*bar[1], b=255*bar[0].
  2 XOR: r=g=b=h[7:0] XOR v[7:0].
  3 scroll: r=(h+frame) mod 256, g=(v+frame) mod 256, b=(h+v) mod 256.
REQ-013 All 8-bit arithmetic SHALL wrap modulo 256 with no saturation.
REQ-014 frame SHALL increment by 1 at each frame boundary (h=799, v=524 -> 0,0) when pause=0; 255 wraps to 0; pause=1 holds value.
REQ-015 Frame-boundary mode load and frame increment on the same edge SHALL both take effect; the new frame value is used from pixel (0,0) onward.

Reset
REQ-016 While rst_n=0: h=0, v=0, frame=0, active mode=0, hsync=1, vsync=1, hblank=1, vblank=1, r=g=b=0.
REQ-017 Reset assertion SHALL take effect immediately, independent of clk; mid-line or mid-frame assertion discards all state.
REQ-018 First rising edge after release SHALL present pixel (0,0) outputs: hblank=0, vblank=0, hsync=1, vsync=1, pixel per mode 0 (r=0, g=0, b=0).
REQ-019 mode SHALL not be sampled at reset release; active mode is 0 until the first frame boundary.

Verification
REQ-020 Release reset, count edges -> hsync=0 exactly on edges 657..752; hblank=1 on edges 641..800; period 800 clocks.
REQ-021 Run one frame -> vsync low for 1600 clocks starting at edge 490*800+1; vblank high for 45*800 clocks; frame=1 after edge 420000.
REQ-022 mode=1 set before first boundary -> second frame line 0: r,g,b = (0,0,0) px 0..79, (0,0,255) px 80..159, ..., (255,255,255) px 560..639, then 0 in blanking.
REQ-023 Toggle mode 0->2 at v=100 -> current frame stays mode 0; next frame pixel (3,5) r=g=b=6.
REQ-024 pause=1 across 3 frame boundaries -> frame unchanged; run 256 frames with pause=0 -> frame wraps to 0.
REQ-025 Assert rst_n=0 asynchronously at h=300, v=200 -> outputs take REQ-016 values before the next clk edge; after release, edge 1 shows pixel (0,0).

Source files
------------

// File: rtl/vga_fun_ctrl.sv
// VGA 640x480 timing generator with four selectable test patterns and a frame counter.
// All outputs are registered: each edge presents the pixel at the (h, v) held before it.
module vga_fun_ctrl #(
   parameter int unsigned H_VIS  = 640,
   parameter int unsigned H_FP   = 16,
   parameter int unsigned H_SYNC = 96,
   parameter int unsigned H_BP   = 48,
   parameter int unsigned V_VIS  = 480,
   parameter int unsigned V_FP   = 10,
   parameter int unsigned V_SYNC = 2,
   parameter int unsigned V_BP   = 33
) (
   input  logic       clk,
   input  logic       rst_n,
   input  logic [1:0] mode,
   input  logic       pause,
   output logic       hsync,
   output logic       vsync,
   output logic       hblank,
   output logic       vblank,
   output logic [7:0] r,
   output logic [7:0] g,
   output logic [7:0] b,
   output logic [7:0] frame
);

   localparam int unsigned H_TOTAL = H_VIS + H_FP + H_SYNC + H_BP;
   localparam int unsigned V_TOTAL = V_VIS + V_FP + V_SYNC + V_BP;
   // Counters are at least 8 bits wide so the pattern logic can always take [7:0].
   localparam int unsigned HW = ($clog2(H_TOTAL) > 8) ? $clog2(H_TOTAL) : 8;
   localparam int unsigned VW = ($clog2(V_TOTAL) > 8) ? $clog2(V_TOTAL) : 8;
   localparam int unsigned BAR_W = 80;

   logic [HW-1:0] h_q, h_d;
   logic [VW-1:0] v_q, v_d;
   logic [1:0]    mode_q, mode_d;
   logic [7:0]    frame_q, frame_d;
   logic          h_end, v_end, frame_end;

   logic          hsync_q, vsync_q, hblank_q, vblank_q;
   logic          hsync_d, vsync_d, hblank_d, vblank_d;
   logic [7:0]    r_q, g_q, b_q, r_d, g_d, b_d;
   logic [7:0]    hl, vl;
   logic [2:0]    bar;

   always_comb begin
      h_end     = (h_q == HW'(H_TOTAL - 1));
      v_end     = (v_q == VW'(V_TOTAL - 1));
      frame_end = h_end && v_end;
      h_d       = h_end ? '0 : h_q + 1'b1;
      v_d       = v_q;
      if (h_end) begin
         v_d = v_end ? '0 : v_q + 1'b1;
      end
      mode_d  = frame_end ? mode : mode_q;
      frame_d = (frame_end && !pause) ? frame_q + 8'd1 : frame_q;
   end

   always_comb begin
      hblank_d = !(h_q < HW'(H_VIS));
      vblank_d = !(v_q < VW'(V_VIS));
      hsync_d  = !((h_q >= HW'(H_VIS + H_FP)) && (h_q < HW'(H_VIS + H_FP + H_SYNC)));
      vsync_d  = !((v_q >= VW'(V_VIS + V_FP)) && (v_q < VW'(V_VIS + V_FP + V_SYNC)));
      hl       = h_q[7:0];
      vl       = v_q[7:0];
      bar      = 3'(h_q / HW'(BAR_W));
      r_d      = 8'd0;
      g_d      = 8'd0;
      b_d      = 8'd0;
      case (mode_q)
         2'd0: begin
            r_d = hl;
            g_d = vl;
            b_d = frame_q;
         end
         2'd1: begin
            r_d = {8{bar[2]}};
            g_d = {8{bar[1]}};
            b_d = {8{bar[0]}};
         end
         2'd2: begin
            r_d = hl ^ vl;
            g_d = hl ^ vl;
            b_d = hl ^ vl;
         end
         default: begin
            r_d = hl + frame_q;
            g_d = vl + frame_q;
            b_d = hl + vl;
         end
      endcase
      if (hblank_d || vblank_d) begin
         r_d = 8'd0;
         g_d = 8'd0;
         b_d = 8'd0;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         h_q      <= '0;
         v_q      <= '0;
         mode_q   <= 2'd0;
         frame_q  <= 8'd0;
         hsync_q  <= 1'b1;
         vsync_q  <= 1'b1;
         hblank_q <= 1'b1;
         vblank_q <= 1'b1;
         r_q      <= 8'd0;
         g_q      <= 8'd0;
         b_q      <= 8'd0;
      end else begin
         h_q      <= h_d;
         v_q      <= v_d;
         mode_q   <= mode_d;
         frame_q  <= frame_d;
         hsync_q  <= hsync_d;
         vsync_q  <= vsync_d;
         hblank_q <= hblank_d;
         vblank_q <= vblank_d;
         r_q      <= r_d;
         g_q      <= g_d;
         b_q      <= b_d;
      end
   end

   assign hsync  = hsync_q;
   assign vsync  = vsync_q;
   assign hblank = hblank_q;
   assign vblank = vblank_q;
   assign r      = r_q;
   assign g      = g_q;
   assign b      = b_q;
   assign frame  = frame_q;

endmodule

// File: tb/tb_vga_fun_ctrl.sv
// Bench for vga_fun_ctrl: a full-width instance with a short frame and a tiny instance for
// frame-counter wrap, both checked edge by edge against a positional reference model.
module tb_vga_fun_ctrl;

   localparam int MHV = 640, MHF = 16, MHS = 96, MHB = 48;
   localparam int MVV = 6, MVF = 1, MVS = 2, MVB = 1;
   localparam int M_HT = MHV + MHF + MHS + MHB;
   localparam int M_VT = MVV + MVF + MVS + MVB;
   localparam int M_FT = M_HT * M_VT;
   localparam int SHV = 8, SHF = 2, SHS = 3, SHB = 3;
   localparam int SVV = 4, SVF = 1, SVS = 1, SVB = 2;
   localparam int S_HT = SHV + SHF + SHS + SHB;
   localparam int S_VT = SVV + SVF + SVS + SVB;
   localparam int S_FT = S_HT * S_VT;

   localparam logic [35:0] RST_VAL = 36'hF_0000_0000;
   localparam logic [35:0] PIX00   = 36'hC_0000_0000;

   logic       clk = 1'b0;
   logic       rst_n, pause, t_rst_n, t_pause;
   logic [1:0] mode, t_mode;
   logic       hs, vs, hb, vb, t_hs, t_vs, t_hb, t_vb;
   logic [7:0] r, g, b, fr, t_r, t_g, t_b, t_fr;
   logic [35:0] main_out, tiny_out;

   int checks   = 0;
   int failures = 0;
   int m_t, m_frame, m_mode, s_t, s_frame, s_mode;

   always #5 clk = ~clk;

   vga_fun_ctrl #(
      .H_VIS(MHV), .H_FP(MHF), .H_SYNC(MHS), .H_BP(MHB),
      .V_VIS(MVV), .V_FP(MVF), .V_SYNC(MVS), .V_BP(MVB)
   ) dut (
      .clk(clk), .rst_n(rst_n), .mode(mode), .pause(pause),
      .hsync(hs), .vsync(vs), .hblank(hb), .vblank(vb),
      .r(r), .g(g), .b(b), .frame(fr)
   );

   vga_fun_ctrl #(
      .H_VIS(SHV), .H_FP(SHF), .H_SYNC(SHS), .H_BP(SHB),
      .V_VIS(SVV), .V_FP(SVF), .V_SYNC(SVS), .V_BP(SVB)
   ) dut_tiny (
      .clk(clk), .rst_n(t_rst_n), .mode(t_mode), .pause(t_pause),
      .hsync(t_hs), .vsync(t_vs), .hblank(t_hb), .vblank(t_vb),
      .r(t_r), .g(t_g), .b(t_b), .frame(t_fr)
   );

   assign main_out = {hs, vs, hb, vb, r, g, b, fr};
   assign tiny_out = {t_hs, t_vs, t_hb, t_vb, t_r, t_g, t_b, t_fr};

   // Expected sync/blank/colour for one pixel position, straight from the pattern rules.
   function automatic logic [27:0] pix(int h, int v, int f, int md, int hv, int hf, int hsn,
                                       int vv, int vf, int vsn);
      logic       hsy, vsy, hbl, vbl;
      logic [7:0] rr, gg, bb;
      int         bar;
      hbl = (h >= hv);
      vbl = (v >= vv);
      hsy = !((h >= hv + hf) && (h < hv + hf + hsn));
      vsy = !((v >= vv + vf) && (v < vv + vf + vsn));
      rr = 8'd0; gg = 8'd0; bb = 8'd0;
      if (!hbl && !vbl) begin
         case (md)
            0: begin
               rr = 8'(h % 256); gg = 8'(v % 256); bb = 8'(f % 256);
            end
            1: begin
               bar = h / 80;
               rr = ((bar / 4) % 2 == 1) ? 8'd255 : 8'd0;
               gg = ((bar / 2) % 2 == 1) ? 8'd255 : 8'd0;
               bb = (bar % 2 == 1) ? 8'd255 : 8'd0;
            end
            2: begin
               rr = 8'((h % 256) ^ (v % 256)); gg = rr; bb = rr;
            end
            default: begin
               rr = 8'((h + f) % 256); gg = 8'((v + f) % 256); bb = 8'((h + v) % 256);
            end
         endcase
      end
      return {hsy, vsy, hbl, vbl, rr, gg, bb};
   endfunction

   // Advance one clock edge and produce the expected output vector for that edge.
   task automatic tick(input bit tiny, output logic [35:0] e);
      logic [1:0]  md_in;
      logic        p_in;
      logic [27:0] px;
      md_in = tiny ? t_mode : mode;
      p_in  = tiny ? t_pause : pause;
      @(posedge clk);
      #1;
      if (!tiny) begin
         px = pix(m_t % M_HT, (m_t / M_HT) % M_VT, m_frame, m_mode,
                  MHV, MHF, MHS, MVV, MVF, MVS);
         if (m_t % M_FT == M_FT - 1) begin
            m_mode = int'(md_in);
            if (!p_in) m_frame = (m_frame + 1) % 256;
         end
         m_t++;
         e = {px, 8'(m_frame)};
      end else begin
         px = pix(s_t % S_HT, (s_t / S_HT) % S_VT, s_frame, s_mode,
                  SHV, SHF, SHS, SVV, SVF, SVS);
         if (s_t % S_FT == S_FT - 1) begin
            s_mode = int'(md_in);
            if (!p_in) s_frame = (s_frame + 1) % 256;
         end
         s_t++;
         e = {px, 8'(s_frame)};
      end
   endtask

   task automatic test_reset();
      rst_n = 1'b0; t_rst_n = 1'b0; pause = 1'b0; t_pause = 1'b0;
      mode = 2'($urandom_range(1, 3)); t_mode = 2'($urandom);
      repeat (3) @(posedge clk);
      #1;
      checks++;
      if (main_out !== RST_VAL) begin
         failures++;
         $display("FAIL reset_main got=%h exp=%h", main_out, RST_VAL);
      end
      checks++;
      if (tiny_out !== RST_VAL) begin
         failures++;
         $display("FAIL reset_tiny got=%h exp=%h", tiny_out, RST_VAL);
      end
      @(negedge clk);
      rst_n = 1'b1;
      m_t = 0; m_frame = 0; m_mode = 0;
   endtask

   task automatic test_first_line();
      logic [35:0] e;
      int first_hs = -1, hs_n = 0, first_hb = -1, hb_n = 0;
      for (int n = 1; n <= M_HT; n++) begin
         tick(1'b0, e);
         checks++;
         if (main_out !== e) begin
            failures++;
            $display("FAIL line0_px edge=%0d got=%h exp=%h", n, main_out, e);
         end
         if (n == 1) begin
            checks++;
            if (main_out !== PIX00) begin
               failures++;
               $display("FAIL first_edge got=%h exp=%h", main_out, PIX00);
            end
         end
         if (!main_out[35]) begin
            hs_n++;
            if (first_hs < 0) first_hs = n;
         end
         if (main_out[33]) begin
            hb_n++;
            if (first_hb < 0) first_hb = n;
         end
      end
      checks++;
      if (first_hs != 657 || hs_n != 96) begin
         failures++;
         $display("FAIL hsync_window got=%0d/%0d exp=657/96", first_hs, hs_n);
      end
      checks++;
      if (first_hb != 641 || hb_n != 160) begin
         failures++;
         $display("FAIL hblank_window got=%0d/%0d exp=641/160", first_hb, hb_n);
      end
   endtask

   task automatic test_frames();
      logic [35:0] e;
      int pre, rel, fidx, vs_low = 0, vb_high = 0;
      while (m_t < 3 * M_FT) begin
         pre  = m_t;
         rel  = pre % M_FT;
         fidx = pre / M_FT;
         if (fidx == 0) begin
            if (rel < 7000 && $urandom_range(0, 399) == 0) mode = 2'($urandom);
            if (rel == 7500) mode = 2'd1;
         end else if (fidx == 1) begin
            if (rel < 2000 && $urandom_range(0, 399) == 0) mode = 2'($urandom);
            if (rel == 2400) mode = 2'd2;
         end else if ($urandom_range(0, 399) == 0) begin
            mode = 2'($urandom);
         end
         tick(1'b0, e);
         checks++;
         if (main_out !== e) begin
            failures++;
            $display("FAIL frame_px t=%0d got=%h exp=%h", pre, main_out, e);
         end
         if (fidx == 0) begin
            vs_low  += int'(!main_out[34]);
            vb_high += int'(main_out[32]);
         end
         if (pre == M_FT - 1) begin
            checks++;
            if (fr !== 8'd1) begin
               failures++;
               $display("FAIL frame_incr got=%0d exp=1", fr);
            end
         end
         if (pre == M_FT + 600) begin
            checks++;
            if ({r, g, b} !== 24'hFFFFFF) begin
               failures++;
               $display("FAIL bar7 got=%h exp=ffffff", {r, g, b});
            end
         end
         if (pre == 2 * M_FT + 5 * M_HT + 3) begin
            checks++;
            if ({r, g, b} !== 24'h060606) begin
               failures++;
               $display("FAIL xor_3_5 got=%h exp=060606", {r, g, b});
            end
         end
      end
      checks++;
      if (vs_low != MVS * M_HT || vb_high != (M_VT - MVV) * M_HT) begin
         failures++;
         $display("FAIL vwindow got=%0d/%0d exp=%0d/%0d", vs_low, vb_high,
                  MVS * M_HT, (M_VT - MVV) * M_HT);
      end
   endtask

   task automatic test_async_reset();
      logic [35:0] e;
      while (m_t % M_FT != 2 * M_HT + 300) begin
         tick(1'b0, e);
         checks++;
         if (main_out !== e) begin
            failures++;
            $display("FAIL pre_reset_px t=%0d got=%h exp=%h", m_t, main_out, e);
         end
      end
      #2;
      rst_n = 1'b0;
      #1;
      checks++;
      if (main_out !== RST_VAL) begin
         failures++;
         $display("FAIL async_reset got=%h exp=%h", main_out, RST_VAL);
      end
      mode = 2'd3;
      repeat (2) @(negedge clk);
      rst_n = 1'b1;
      m_t = 0; m_frame = 0; m_mode = 0;
      tick(1'b0, e);
      checks++;
      if (main_out !== PIX00 || e !== PIX00) begin
         failures++;
         $display("FAIL post_reset_px00 got=%h exp=%h", main_out, PIX00);
      end
   endtask

   task automatic test_pause_wrap();
      logic [35:0] e;
      bit saw255 = 1'b0;
      rst_n = 1'b0;
      t_pause = 1'b1;
      t_mode = 2'($urandom);
      @(negedge clk);
      t_rst_n = 1'b1;
      s_t = 0; s_frame = 0; s_mode = 0;
      while (s_t < 3 * S_FT + 10) begin
         if ($urandom_range(0, 49) == 0) t_mode = 2'($urandom);
         tick(1'b1, e);
         checks++;
         if (tiny_out !== e) begin
            failures++;
            $display("FAIL pause_px t=%0d got=%h exp=%h", s_t, tiny_out, e);
         end
      end
      checks++;
      if (t_fr !== 8'd0) begin
         failures++;
         $display("FAIL pause_hold got=%0d exp=0", t_fr);
      end
      t_pause = 1'b0;
      repeat (256 * S_FT) begin
         if ($urandom_range(0, 99) == 0) t_mode = 2'($urandom);
         tick(1'b1, e);
         checks++;
         if (tiny_out !== e) begin
            failures++;
            $display("FAIL wrap_px t=%0d got=%h exp=%h", s_t, tiny_out, e);
         end
         if (t_fr === 8'd255) saw255 = 1'b1;
      end
      checks++;
      if (t_fr !== 8'd0 || !saw255) begin
         failures++;
         $display("FAIL frame_wrap got=%0d saw255=%0d exp=0 saw255=1", t_fr, saw255);
      end
   endtask

   initial begin
      test_reset();
      test_first_line();
      test_frames();
      test_async_reset();
      test_pause_wrap();
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
